// File: rtl/conv2d_im2col_pkg.sv
// conv2d_im2col shared geometry and FSM encodings.
// Keeps im2col producer and its consumers on identical window geometry.
package conv2d_im2col_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_PACK = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic int out_dim(
    input int img,
    input int ker,
    input int pad,
    input int stride
  );
    return (img - ker + 2 * pad) / stride + 1;
  endfunction

endpackage

// File: rtl/conv2d_window_extract.sv
// conv2d_window_extract: one padded kernel-sized window of a flat image.
// Element (0,0) lands in the MSB slice; out-of-image taps read as zero.
module conv2d_window_extract #(
  parameter int BITWIDTH      = 8,
  parameter int IMAGE_WIDTH   = 5,
  parameter int IMAGE_HEIGHT  = 5,
  parameter int WEIGHT_WIDTH  = 3,
  parameter int WEIGHT_HEIGHT = 3,
  parameter int STRIDE        = 1,
  parameter int PADDING       = 0,
  parameter int OX            = 0,
  parameter int OY            = 0
) (
  input  logic [IMAGE_WIDTH*IMAGE_HEIGHT*BITWIDTH-1:0]   i_img,
  output logic [WEIGHT_WIDTH*WEIGHT_HEIGHT*BITWIDTH-1:0] o_win
);

  localparam int NEL = WEIGHT_WIDTH * WEIGHT_HEIGHT;

  always_comb begin
    int r;
    int c;
    o_win = '0;
    r = 0;
    c = 0;
    for (int ky = 0; ky < WEIGHT_HEIGHT; ky++) begin
      for (int kx = 0; kx < WEIGHT_WIDTH; kx++) begin
        r = OY * STRIDE + ky - PADDING;
        c = OX * STRIDE + kx - PADDING;
        if (r >= 0 && r < IMAGE_HEIGHT &&
            c >= 0 && c < IMAGE_WIDTH) begin
          o_win[(NEL-1-(ky*WEIGHT_WIDTH+kx))*BITWIDTH +: BITWIDTH] =
            i_img[(r*IMAGE_WIDTH+c)*BITWIDTH +: BITWIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/conv2d_im2col.sv
// conv2d_im2col: buffers one raster frame, then presents all
// padded/strided windows on a flat bus with a valid/ready hold.
module conv2d_im2col
  import conv2d_im2col_pkg::*;
#(
  parameter int BITWIDTH      = 8,
  parameter int IMAGE_WIDTH   = 5,
  parameter int IMAGE_HEIGHT  = 5,
  parameter int WEIGHT_WIDTH  = 3,
  parameter int WEIGHT_HEIGHT = 3,
  parameter int STRIDE        = 1,
  parameter int PADDING       = 0,
  localparam int OUT_W =
    out_dim(IMAGE_WIDTH, WEIGHT_WIDTH, PADDING, STRIDE),
  localparam int OUT_H =
    out_dim(IMAGE_HEIGHT, WEIGHT_HEIGHT, PADDING, STRIDE),
  localparam int FEATURE_MAP_NUM = OUT_W * OUT_H,
  localparam int WIN = WEIGHT_WIDTH * WEIGHT_HEIGHT * BITWIDTH,
  localparam int FMW = FEATURE_MAP_NUM * WIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FMW-1:0]      feature_maps,
  output logic                frame_err
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CW-1:0]              r_pix_cnt;
  logic [CW-1:0]              w_pix_cnt_nxt;
  logic                       r_frame_err;
  logic                       w_frame_err_nxt;
  logic [NPIX*BITWIDTH-1:0]   r_img;
  logic [FMW-1:0]             r_fm;
  logic [FMW-1:0]             w_fm;
  logic                       w_accept;
  logic                       w_final;

  assign in_ready     = (r_state == ST_LOAD);
  assign out_valid    = (r_state == ST_HOLD);
  assign feature_maps = r_fm;
  assign frame_err    = r_frame_err;
  assign w_accept     = in_valid & in_ready;
  assign w_final      = (r_pix_cnt == CW'(NPIX - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_pix_cnt_nxt   = r_pix_cnt;
    w_frame_err_nxt = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          if (w_final) begin
            w_state_nxt     = ST_PACK;
            w_pix_cnt_nxt   = '0;
            w_frame_err_nxt = ~in_last;
          end else if (in_last) begin
            w_pix_cnt_nxt   = '0;
            w_frame_err_nxt = 1'b1;
          end else begin
            w_pix_cnt_nxt   = r_pix_cnt + 1'b1;
          end
        end
      end
      ST_PACK: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_LOAD;
      r_pix_cnt   <= '0;
      r_frame_err <= 1'b0;
      r_fm        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix_cnt   <= w_pix_cnt_nxt;
      r_frame_err <= w_frame_err_nxt;
      if (r_state == ST_PACK) r_fm <= w_fm;
    end
  end

  // Buffer has no reset: every slot is rewritten before PACK reads it.
  always_ff @(posedge clk) begin
    if (!rst && w_accept)
      r_img[r_pix_cnt*BITWIDTH +: BITWIDTH] <= in_data;
  end

  for (genvar gy = 0; gy < OUT_H; gy++) begin : g_row
    for (genvar gx = 0; gx < OUT_W; gx++) begin : g_col
      localparam int M = gy * OUT_W + gx;
      conv2d_window_extract #(
        .BITWIDTH      (BITWIDTH),
        .IMAGE_WIDTH   (IMAGE_WIDTH),
        .IMAGE_HEIGHT  (IMAGE_HEIGHT),
        .WEIGHT_WIDTH  (WEIGHT_WIDTH),
        .WEIGHT_HEIGHT (WEIGHT_HEIGHT),
        .STRIDE        (STRIDE),
        .PADDING       (PADDING),
        .OX            (gx),
        .OY            (gy)
      ) u_win (
        .i_img (r_img),
        .o_win (w_fm[(FEATURE_MAP_NUM-1-M)*WIN +: WIN])
      );
    end
  end

endmodule

// File: tb/tb_conv2d_im2col.sv
// tb_conv2d_im2col: directed table checks of conv2d_im2col in three
// geometries plus handshake, framing and reset sequences.
module tb_conv2d_im2col;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_valid, a_last, a_oready;
  logic [7:0]   a_data;
  logic         a_iready, a_ovalid, a_err;
  logic [647:0] a_fm;
  logic         c_iready, c_ovalid, c_err;
  logic [287:0] c_fm;
  logic         b_valid, b_last, b_oready;
  logic [7:0]   b_data;
  logic         b_iready, b_ovalid, b_err;
  logic [647:0] b_fm;

  conv2d_im2col u_a (
    .clk (clk), .rst (rst),
    .in_valid (a_valid), .in_ready (a_iready),
    .in_data (a_data), .in_last (a_last),
    .out_valid (a_ovalid), .out_ready (a_oready),
    .feature_maps (a_fm), .frame_err (a_err)
  );

  conv2d_im2col #(.STRIDE(2)) u_c (
    .clk (clk), .rst (rst),
    .in_valid (a_valid), .in_ready (c_iready),
    .in_data (a_data), .in_last (a_last),
    .out_valid (c_ovalid), .out_ready (a_oready),
    .feature_maps (c_fm), .frame_err (c_err)
  );

  conv2d_im2col #(
    .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3), .PADDING(1)
  ) u_b (
    .clk (clk), .rst (rst),
    .in_valid (b_valid), .in_ready (b_iready),
    .in_data (b_data), .in_last (b_last),
    .out_valid (b_ovalid), .out_ready (b_oready),
    .feature_maps (b_fm), .frame_err (b_err)
  );

  typedef struct {
    int          dut;
    int          map;
    logic [71:0] exp;
  } vec_t;

  vec_t         vecs[22];
  logic [7:0]   img5[25];
  logic [7:0]   img3[9];
  logic [647:0] exp_a;
  logic [287:0] exp_c;
  int n_run = 0;
  int n_fail = 0;
  int a_errs = 0;
  int b_errs = 0;
  int c_errs = 0;

  always @(negedge clk) begin
    if (a_err === 1'b1) a_errs++;
    if (b_err === 1'b1) b_errs++;
    if (c_err === 1'b1) c_errs++;
  end

  task automatic chk(input string name,
                     input logic [647:0] act,
                     input logic [647:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v,
                       input logic [7:0] d, input logic l);
    if (sel == 0) begin
      a_valid = v; a_data = d; a_last = l;
    end else begin
      b_valid = v; b_data = d; b_last = l;
    end
  endtask

  task automatic send(input int sel, input int n, input int early,
                      input bit last_ok, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int guard;
      logic [7:0] d;
      guard = 0;
      d = (sel == 0) ? img5[i] : img3[i];
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
      end
      @(negedge clk);
      drive(sel, 1'b1, d,
            (last_ok && i == n - 1) || (i == early));
      while (((sel == 0) ? a_iready : b_iready) !== 1'b1 &&
             guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk("send_timeout", 1'b0, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_valid(input int sel, input string name);
    int cnt;
    cnt = 1;
    while (((sel == 0) ? a_ovalid : b_ovalid) !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, cnt, 2);
  endtask

  task automatic handshake(input int sel);
    @(negedge clk);
    if (sel == 0) a_oready = 1'b1; else b_oready = 1'b1;
    @(negedge clk);
    a_oready = 1'b0;
    b_oready = 1'b0;
  endtask

  function automatic logic [71:0] get_map(input int dut, input int m);
    if (dut == 0) return a_fm[(8 - m) * 72 +: 72];
    if (dut == 1) return b_fm[(8 - m) * 72 +: 72];
    return c_fm[(3 - m) * 72 +: 72];
  endfunction

  initial begin
    int e0;
    bit ok;
    logic [647:0] snap;

    img5 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
             8'h06, 8'h07, 8'h08, 8'h09, 8'h0A,
             8'h0B, 8'h0C, 8'h0D, 8'h0C, 8'h0B,
             8'h0A, 8'h09, 8'h08, 8'h07, 8'h06,
             8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    img3 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
             8'h06, 8'h07, 8'h08, 8'h09};

    vecs[0]  = '{0, 0, 72'h010203_060708_0B0C0D};
    vecs[1]  = '{0, 1, 72'h020304_070809_0C0D0C};
    vecs[2]  = '{0, 2, 72'h030405_08090A_0D0C0B};
    vecs[3]  = '{0, 3, 72'h060708_0B0C0D_0A0908};
    vecs[4]  = '{0, 4, 72'h070809_0C0D0C_090807};
    vecs[5]  = '{0, 5, 72'h08090A_0D0C0B_080706};
    vecs[6]  = '{0, 6, 72'h0B0C0D_0A0908_050403};
    vecs[7]  = '{0, 7, 72'h0C0D0C_090807_040302};
    vecs[8]  = '{0, 8, 72'h0D0C0B_080706_030201};
    vecs[9]  = '{1, 0, 72'h000000_000102_000405};
    vecs[10] = '{1, 1, 72'h000000_010203_040506};
    vecs[11] = '{1, 2, 72'h000000_020300_050600};
    vecs[12] = '{1, 3, 72'h000102_000405_000708};
    vecs[13] = '{1, 4, 72'h010203_040506_070809};
    vecs[14] = '{1, 5, 72'h020300_050600_080900};
    vecs[15] = '{1, 6, 72'h000405_000708_000000};
    vecs[16] = '{1, 7, 72'h040506_070809_000000};
    vecs[17] = '{1, 8, 72'h050600_080900_000000};
    vecs[18] = '{2, 0, 72'h010203_060708_0B0C0D};
    vecs[19] = '{2, 1, 72'h030405_08090A_0D0C0B};
    vecs[20] = '{2, 2, 72'h0B0C0D_0A0908_050403};
    vecs[21] = '{2, 3, 72'h0D0C0B_080706_030201};

    exp_a = '0;
    exp_c = '0;
    for (int i = 0; i < 9; i++) exp_a = {exp_a[575:0], vecs[i].exp};
    for (int i = 18; i < 22; i++) exp_c = {exp_c[215:0], vecs[i].exp};

    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    a_oready = 1'b0;
    b_oready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", a_iready, 1'b1);
    chk("rst_out_valid", a_ovalid, 1'b0);
    chk("rst_frame_err", a_err, 1'b0);
    chk("rst_fm", a_fm, '0);
    chk("rst_fm_b", b_fm, '0);

    // Default and stride-2 geometry share one clean frame.
    send(0, 25, -1, 1'b1, 1'b0);
    wait_valid(0, "lat_a");
    send(1, 9, -1, 1'b1, 1'b0);
    wait_valid(1, "lat_b");
    chk("no_err_a", a_errs, 0);
    chk("no_err_b", b_errs, 0);
    chk("c_valid", c_ovalid, 1'b1);
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("map_d%0d_m%0d", vecs[i].dut, vecs[i].map),
          get_map(vecs[i].dut, vecs[i].map), vecs[i].exp);
    end
    chk("full_a", a_fm, exp_a);
    chk("full_c", c_fm, exp_c);

    // Hold with stray in_valid beats that must be ignored.
    ok = 1'b1;
    snap = a_fm;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_valid = 1'b1; a_data = 8'hFF; a_last = 1'b0;
      if (a_ovalid !== 1'b1 || a_iready !== 1'b0 || a_fm !== snap)
        ok = 1'b0;
    end
    a_valid = 1'b0;
    chk("hold_stable", ok, 1'b1);
    handshake(0);
    chk("hs_valid_drop", a_ovalid, 1'b0);
    chk("hs_ready_back", a_iready, 1'b1);
    handshake(1);
    chk("hs_b_drop", b_ovalid, 1'b0);

    send(0, 25, -1, 1'b1, 1'b1);
    wait_valid(0, "lat_gaps");
    chk("gaps_a", a_fm, exp_a);
    chk("gaps_c", c_fm, exp_c);
    handshake(0);

    // Missing in_last still completes the frame.
    e0 = a_errs;
    send(0, 25, -1, 1'b0, 1'b0);
    wait_valid(0, "lat_nolast");
    chk("nolast_err", a_errs - e0, 1);
    chk("nolast_fm", a_fm, exp_a);
    handshake(0);

    // Early in_last discards the partial frame.
    e0 = a_errs;
    send(0, 11, 10, 1'b0, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_ovalid !== 1'b0 || a_iready !== 1'b1) ok = 1'b0;
    end
    chk("early_no_valid", ok, 1'b1);
    chk("early_err_pulse", a_errs - e0, 1);
    send(0, 25, -1, 1'b1, 1'b0);
    wait_valid(0, "lat_after_early");
    chk("after_early_fm", a_fm, exp_a);
    handshake(0);

    // Reset mid-load after 12 pixels.
    send(0, 12, -1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", a_iready, 1'b1);
    chk("midrst_valid", a_ovalid, 1'b0);
    send(0, 25, -1, 1'b1, 1'b0);
    wait_valid(0, "lat_after_rst");
    chk("after_rst_fm", a_fm, exp_a);

    // Reset in HOLD drops out_valid without handshake.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("holdrst_valid", a_ovalid, 1'b0);
    chk("holdrst_fm", a_fm, '0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
